instr_fetch_queue: RTL

//  Instruction-fetch front end placed directly upstream of the decoder (ctrl_signal/immediate generation).

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch_queue.sv | 82 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch front end.
//   NOP_INSTR     - instruction presented to decode when the queue is empty
//   INSTR_W/PC_W  - field widths of a queue entry
//   fetch_entry_t - one queue entry {pc, instr}, 64 bits
//   byte_swap()   - reverses byte order of a 32-bit word
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Memory holds instructions big-endian; decode expects little-endian.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small register-based FIFO with combinational head read.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   push, wdata    - write wdata at the tail (caller must not push when full
//                    unless popping in the same cycle)
//   pop            - drop the head entry (caller must not pop when empty)
//   flush          - empty the FIFO; overrides push/pop
//   rdata          - head entry (meaningless when empty)
//   count          - occupancy 0..DEPTH
//   empty, full    - occupancy flags
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: stale entries are never visible while count is 0.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch front end feeding decode.
// Owns the PC, addresses a combinational instruction memory, queues fetched
// words tagged with their PC and hands them to decode over valid/ready.
// A redirect from EX flushes the queue and reloads the PC.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   mem_addr_I      - instruction word address (pc[31:2])
//   mem_rdata_I     - word at mem_addr_I, same cycle
//   redirect_valid  - load redirect_pc and flush the queue
//   redirect_pc     - new PC, low two bits dropped
//   instr_valid     - queue head valid
//   instr_ready     - decode accepts the head
//   instr, instr_pc - head instruction and its PC (NOP / 0 when empty)
//   fifo_count      - queue occupancy
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          SWAP_BYTES = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:2]            mem_addr_I,
    input  logic [31:0]            mem_rdata_I,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [31:0]            instr,
    output logic [31:0]            instr_pc,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int ENTRY_W = $bits(fetch_entry_t);

    logic [PC_W-1:0]    pc;
    logic               push;
    logic               pop;
    logic               q_empty;
    logic               q_full;
    logic [ENTRY_W-1:0] q_head;
    fetch_entry_t       wr_entry;
    fetch_entry_t       head;

    // A redirect kills both the pending pop and this cycle's fetch.
    assign pop  = instr_valid & instr_ready & ~redirect_valid;
    assign push = ~redirect_valid & (~q_full | pop);

    assign wr_entry.pc    = pc;
    assign wr_entry.instr = SWAP_BYTES ? byte_swap(mem_rdata_I) : mem_rdata_I;

    always_ff @(posedge clk) begin
        if (rst)                 pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc & ~32'h3;
        else if (push)           pc <= pc + 32'd4;   // wraps FFFF_FFFC -> 0
    end

    assign mem_addr_I = pc[31:2];

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (q_head),
        .count (fifo_count),
        .empty (q_empty),
        .full  (q_full)
    );

    assign head        = q_head;
    assign instr_valid = ~q_empty;
    assign instr       = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? head.pc    : 32'h0;

endmodule
